// File: rtl/dac_serial_tx_if.sv
// Bus between the equalizer back end and the DAC serializer.
// The sample strobe, word and status flags are grouped with the three DAC pins.
interface dac_serial_tx_if #(
  parameter int W = 16
);
  logic [W-1:0] ys;
  logic         start;
  logic         SYNC;
  logic         SCLK;
  logic         DIN;
  logic         busy;
  logic         done;
  logic         overrun;

  modport master (
    output ys, start,
    input  SYNC, SCLK, DIN, busy, done, overrun
  );

  modport slave (
    input  ys, start,
    output SYNC, SCLK, DIN, busy, done, overrun
  );
endinterface

// File: rtl/dac_serial_tx.sv
// Serial output stage for a 12-bit SPI DAC (PmodDA2-class).
// Shifts each strobed word MSB-first with SYNC/SCLK/DIN.
// Holds one pending word so that a strobe arriving mid-frame is kept.
// All DAC pins and flags are registered copies of the next-state decode, so
// they change only on clk edges and never glitch.
module dac_serial_tx #(
  parameter int CLK_DIV = 2,
  parameter int W       = 16
) (
  input  logic             clk,
  input  logic             Reset,
  dac_serial_tx_if.slave   bus
);

  localparam int DW = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   shreg_reg, shreg_next;
  logic [W-1:0]   pend_reg, pend_next;
  logic           pend_valid_reg, pend_valid_next;
  logic [BW-1:0]  bitcnt_reg, bitcnt_next;
  logic [DW-1:0]  divcnt_reg, divcnt_next;
  logic           overrun_reg, overrun_next;
  logic           sync_reg, sclk_reg, din_reg, busy_reg, done_reg;
  logic           sync_next, sclk_next, din_next, busy_next, done_next;

  // State and output registers; an active-low reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      bitcnt_reg     <= '0;
      divcnt_reg     <= '0;
      overrun_reg    <= 1'b0;
      sync_reg       <= 1'b1;
      sclk_reg       <= 1'b1;
      din_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shreg_reg      <= shreg_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      bitcnt_reg     <= bitcnt_next;
      divcnt_reg     <= divcnt_next;
      overrun_reg    <= overrun_next;
      sync_reg       <= sync_next;
      sclk_reg       <= sclk_next;
      din_reg        <= din_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  // Next-state logic: frame sequencing, pending-word capture and pin decode.
  always_comb begin
    state_next      = state_reg;
    shreg_next      = shreg_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    bitcnt_next     = bitcnt_reg;
    divcnt_next     = divcnt_reg;
    overrun_next    = overrun_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          shreg_next  = bus.ys;
          bitcnt_next = '0;
          divcnt_next = '0;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (divcnt_reg == DIV_LAST) begin
          divcnt_next = '0;
          if (bitcnt_reg == BIT_LAST) begin
            state_next = GAP;
          end else begin
            bitcnt_next = bitcnt_reg + 1'b1;
            shreg_next  = {shreg_reg[W-2:0], 1'b0};
          end
        end else begin
          divcnt_next = divcnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (divcnt_reg == DIV_LAST) begin
          divcnt_next = '0;
          bitcnt_next = '0;
          if (pend_valid_reg) begin
            shreg_next      = pend_reg;
            pend_valid_next = 1'b0;
            state_next      = SHIFT;
          end else begin
            state_next = IDLE;
          end
        end else begin
          divcnt_next = divcnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // A strobe while busy always lands in the pending slot, even on the cycle
    // the slot is being drained, so the older pending word goes out first.
    if (bus.start && (state_reg != IDLE)) begin
      pend_next       = bus.ys;
      pend_valid_next = 1'b1;
      if (pend_valid_reg) begin
        overrun_next = 1'b1;
      end
    end

    sync_next = (state_next != SHIFT);
    sclk_next = (state_next != SHIFT) || (divcnt_next < DIV_HALF);
    din_next  = (state_next == SHIFT) ? shreg_next[W-1] : 1'b0;
    busy_next = (state_next != IDLE);
    done_next = (state_next == GAP) && (divcnt_next == DIV_LAST);
  end

  assign bus.SYNC    = sync_reg;
  assign bus.SCLK    = sclk_reg;
  assign bus.DIN     = din_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.overrun = overrun_reg;

endmodule

// File: tb/tb_dac_serial_tx.sv
// Directed bench for dac_serial_tx: one instance at CLK_DIV=2, one at CLK_DIV=1.
// Monitors record SYNC edges, done pulses, SCLK falls and the words captured
// on SCLK falling edges; the initial block drives strobes and checks results.
`define CHECK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s: observed %0h, expected %0h", tag, (obs), (exp)); \
    end \
  end

module tb_dac_serial_tx;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Cycle counter, read only on negative edges.
  always @(posedge clk) cyc <= cyc + 1;

  dac_serial_tx_if #(.W(16)) ia ();
  dac_serial_tx_if #(.W(16)) ib ();

  dac_serial_tx #(.CLK_DIV(2), .W(16)) dut_a (.clk(clk), .Reset(reset_n), .bus(ia));
  dac_serial_tx #(.CLK_DIV(1), .W(16)) dut_b (.clk(clk), .Reset(reset_n), .bus(ib));

  // Monitor for instance A.
  int          a_fall_q[$], a_rise_q[$], a_done_q[$];
  logic [15:0] a_words[$];
  int          a_nfall = 0;
  int          a_nb = 0;
  logic [15:0] a_sh = '0;
  logic        a_psync = 1'b1, a_psclk = 1'b1;

  always @(negedge clk) begin
    if (ia.SYNC === 1'b0 && a_psync === 1'b1) a_fall_q.push_back(cyc);
    if (ia.SYNC === 1'b1 && a_psync === 1'b0) a_rise_q.push_back(cyc);
    if (ia.done === 1'b1) a_done_q.push_back(cyc);
    if (ia.SCLK === 1'b0 && a_psclk === 1'b1) a_nfall <= a_nfall + 1;
    if (ia.SYNC !== 1'b0) begin
      a_nb <= 0;
    end else if (ia.SCLK === 1'b0 && a_psclk === 1'b1) begin
      a_sh <= {a_sh[14:0], ia.DIN};
      if (a_nb == 15) begin
        a_words.push_back({a_sh[14:0], ia.DIN});
        a_nb <= 0;
      end else begin
        a_nb <= a_nb + 1;
      end
    end
    a_psync <= ia.SYNC;
    a_psclk <= ia.SCLK;
  end

  // Monitor for instance B.
  int          b_fall_q[$], b_rise_q[$], b_done_q[$];
  logic [15:0] b_words[$];
  int          b_nfall = 0;
  int          b_nb = 0;
  logic [15:0] b_sh = '0;
  logic        b_psync = 1'b1, b_psclk = 1'b1;

  always @(negedge clk) begin
    if (ib.SYNC === 1'b0 && b_psync === 1'b1) b_fall_q.push_back(cyc);
    if (ib.SYNC === 1'b1 && b_psync === 1'b0) b_rise_q.push_back(cyc);
    if (ib.done === 1'b1) b_done_q.push_back(cyc);
    if (ib.SCLK === 1'b0 && b_psclk === 1'b1) b_nfall <= b_nfall + 1;
    if (ib.SYNC !== 1'b0) begin
      b_nb <= 0;
    end else if (ib.SCLK === 1'b0 && b_psclk === 1'b1) begin
      b_sh <= {b_sh[14:0], ib.DIN};
      if (b_nb == 15) begin
        b_words.push_back({b_sh[14:0], ib.DIN});
        b_nb <= 0;
      end else begin
        b_nb <= b_nb + 1;
      end
    end
    b_psync <= ib.SYNC;
    b_psclk <= ib.SCLK;
  end

  task automatic pulse_a(input logic [15:0] w);
    ia.ys    = w;
    ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    ia.ys    = 16'hDEAD;
  endtask

  task automatic pulse_b(input logic [15:0] w);
    ib.ys    = w;
    ib.start = 1'b1;
    @(negedge clk);
    ib.start = 1'b0;
    ib.ys    = 16'hBEEF;
  endtask

  // Advance to the negedge where cyc - s == rel (bounded by rel).
  task automatic wait_to(input int s, input int rel);
    while (cyc - s < rel) @(negedge clk);
  endtask

  initial begin
    int s, f0, r0, d0, w0, n0, bad;

    reset_n  = 1'b0;
    ia.start = 1'b0; ia.ys = '0;
    ib.start = 1'b0; ib.ys = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    `CHECK("rst_sync", ia.SYNC, 1'b1)
    `CHECK("rst_sclk", ia.SCLK, 1'b1)
    `CHECK("rst_din", ia.DIN, 1'b0)
    `CHECK("rst_busy", ia.busy, 1'b0)
    `CHECK("rst_done", ia.done, 1'b0)
    `CHECK("rst_overrun", ia.overrun, 1'b0)
    `CHECK("rst_b_sync", ib.SYNC, 1'b1)
    `CHECK("rst_b_sclk", ib.SCLK, 1'b1)

    // Idle: no SCLK activity for 100 cycles
    n0 = a_nfall; f0 = a_fall_q.size(); bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (ia.SCLK !== 1'b1 || ia.SYNC !== 1'b1) bad++;
    end
    `CHECK("idle_pins_static", bad, 0)
    `CHECK("idle_no_sclk_falls", a_nfall - n0, 0)
    `CHECK("idle_no_frames", a_fall_q.size() - f0, 0)
    `CHECK("idle_b_no_sclk_falls", b_nfall, 0)

    // Single frame 0A5C
    f0 = a_fall_q.size(); r0 = a_rise_q.size(); d0 = a_done_q.size();
    w0 = a_words.size(); n0 = a_nfall;
    s = cyc;
    pulse_a(16'h0A5C);
    `CHECK("single_sync_low_c1", ia.SYNC, 1'b0)
    `CHECK("single_busy_c1", ia.busy, 1'b1)
    `CHECK("single_din_msb_c1", ia.DIN, 1'b0)
    wait_to(s, 68);
    `CHECK("single_done_c68", ia.done, 1'b1)
    `CHECK("single_busy_c68", ia.busy, 1'b1)
    wait_to(s, 69);
    `CHECK("single_busy_c69", ia.busy, 1'b0)
    `CHECK("single_done_c69", ia.done, 1'b0)
    wait_to(s, 75);
    `CHECK("single_sync_fall", a_fall_q[f0] - s, 1)
    `CHECK("single_sync_rise", a_rise_q[r0] - s, 65)
    `CHECK("single_done_cycle", a_done_q[d0] - s, 68)
    `CHECK("single_done_count", a_done_q.size() - d0, 1)
    `CHECK("single_sclk_falls", a_nfall - n0, 16)
    `CHECK("single_word", a_words[w0], 16'h0A5C)

    // Back-to-back 0FFF then 0001
    f0 = a_fall_q.size(); d0 = a_done_q.size(); w0 = a_words.size();
    s = cyc;
    pulse_a(16'h0FFF);
    wait_to(s, 20);
    pulse_a(16'h0001);
    wait_to(s, 69);
    `CHECK("b2b_busy_c69", ia.busy, 1'b1)
    `CHECK("b2b_sync_c69", ia.SYNC, 1'b0)
    wait_to(s, 140);
    `CHECK("b2b_second_fall", a_fall_q[f0 + 1] - s, 69)
    `CHECK("b2b_first_done", a_done_q[d0] - s, 68)
    `CHECK("b2b_second_done", a_done_q[d0 + 1] - s, 136)
    `CHECK("b2b_word0", a_words[w0], 16'h0FFF)
    `CHECK("b2b_word1", a_words[w0 + 1], 16'h0001)
    `CHECK("b2b_overrun", ia.overrun, 1'b0)
    `CHECK("b2b_busy_end", ia.busy, 1'b0)

    // Overrun: 0111, 0222, 0333
    w0 = a_words.size();
    s = cyc;
    pulse_a(16'h0111);
    wait_to(s, 10);
    pulse_a(16'h0222);
    wait_to(s, 20);
    `CHECK("ovr_before", ia.overrun, 1'b0)
    pulse_a(16'h0333);
    `CHECK("ovr_set_c21", ia.overrun, 1'b1)
    wait_to(s, 140);
    `CHECK("ovr_word_count", a_words.size() - w0, 2)
    `CHECK("ovr_word0", a_words[w0], 16'h0111)
    `CHECK("ovr_word1", a_words[w0 + 1], 16'h0333)
    `CHECK("ovr_sticky", ia.overrun, 1'b1)

    // Reset mid-frame with a word pending
    w0 = a_words.size();
    s = cyc;
    pulse_a(16'h0123);
    wait_to(s, 10);
    pulse_a(16'h0456);
    wait_to(s, 30);
    reset_n = 1'b0;
    @(negedge clk);
    `CHECK("midrst_sync", ia.SYNC, 1'b1)
    `CHECK("midrst_sclk", ia.SCLK, 1'b1)
    `CHECK("midrst_din", ia.DIN, 1'b0)
    `CHECK("midrst_busy", ia.busy, 1'b0)
    `CHECK("midrst_done", ia.done, 1'b0)
    `CHECK("midrst_overrun", ia.overrun, 1'b0)
    reset_n = 1'b1;
    f0 = a_fall_q.size();
    repeat (100) @(negedge clk);
    `CHECK("midrst_pending_dropped", a_fall_q.size() - f0, 0)
    `CHECK("midrst_no_partial_word", a_words.size() - w0, 0)
    n0 = a_nfall;
    s = cyc;
    pulse_a(16'h0789);
    wait_to(s, 75);
    `CHECK("midrst_clean_count", a_words.size() - w0, 1)
    `CHECK("midrst_clean_word", a_words[w0], 16'h0789)
    `CHECK("midrst_clean_falls", a_nfall - n0, 16)

    // CLK_DIV=1 instance, FFFF
    f0 = b_fall_q.size(); r0 = b_rise_q.size(); d0 = b_done_q.size();
    w0 = b_words.size(); n0 = b_nfall;
    s = cyc;
    pulse_b(16'hFFFF);
    `CHECK("div1_sclk_c1", ib.SCLK, 1'b1)
    @(negedge clk);
    `CHECK("div1_sclk_c2", ib.SCLK, 1'b0)
    wait_to(s, 34);
    `CHECK("div1_done_c34", ib.done, 1'b1)
    wait_to(s, 40);
    `CHECK("div1_sync_fall", b_fall_q[f0] - s, 1)
    `CHECK("div1_sync_low_len", b_rise_q[r0] - b_fall_q[f0], 32)
    `CHECK("div1_done_cycle", b_done_q[d0] - s, 34)
    `CHECK("div1_sclk_falls", b_nfall - n0, 16)
    `CHECK("div1_word", b_words[w0], 16'hFFFF)
    `CHECK("div1_busy_end", ib.busy, 1'b0)

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
